pipe_ctrl: RTL and testbench



---
 rtl/pipe_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage sMIPS core: stall arbitration, exception flush,
// mispredict redirect and stall watchdog. Optional perf counter: PIPE_PERF_CNT_EN.
module pipe_ctrl #(
    parameter int FLUSH_CYCLES  = 1,
    parameter int STALL_TIMEOUT = 1024,
    parameter int TO_W          = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        mispredict_i,
    input  logic [31:0] redirect_pc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        redirect,
    output logic        stall_timeout,
    output logic [31:0] stall_cycles
);

    localparam logic [31:0]     ZERO_WORD  = 32'h0000_0000;
    localparam logic [31:0]     EXC_ERET   = 32'h0000_000e;
    localparam logic [31:0]     EXC_VECTOR = 32'h0000_0020;
    localparam logic            MULTI_FLUSH = (FLUSH_CYCLES > 1);
    localparam logic [1:0]      FLUSH_LOAD  = (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;
    localparam logic [TO_W-1:0] TO_LIMIT   = TO_W'(STALL_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(STALL_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1
    } state_t;

    state_t      state, state_next;
    logic [1:0]  flush_cnt;
    logic [31:0] flush_pc;
    logic        pend_valid;
    logic [31:0] pend_pc;
    logic [5:0]  stall_enc;
    logic        exc_valid;
    logic        exc_entry;
    logic        run_clean;
    logic        fire_redirect;
    logic [31:0] exc_target;
    logic [31:0] redirect_target;
    logic [TO_W-1:0] to_cnt;

    assign exc_valid       = (excepttype_i != ZERO_WORD);
    assign exc_entry       = (state == ST_RUN) && exc_valid;
    assign run_clean       = (state == ST_RUN) && !exc_valid;
    assign exc_target      = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
    // A mispredict seen in the current cycle is newer than any held one.
    assign redirect_target = mispredict_i ? redirect_pc_i : pend_pc;
    assign fire_redirect   = run_clean && !stallreq_mem && (mispredict_i || pend_valid);

    always_comb begin
        if (stallreq_mem)     stall_enc = 6'b011111;
        else if (stallreq_ex) stall_enc = 6'b001111;
        else if (stallreq_id) stall_enc = 6'b000111;
        else if (stallreq_if) stall_enc = 6'b000011;
        else                  stall_enc = 6'b000000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_RUN;
        else     state <= state_next;
    end

    // The entry cycle is itself the first flush cycle, so a single-cycle flush never leaves RUN.
    always_comb begin
        state_next = ST_RUN;
        case (state)
            ST_RUN:   state_next = (exc_valid && MULTI_FLUSH) ? ST_FLUSH : ST_RUN;
            ST_FLUSH: state_next = (flush_cnt == 2'd0) ? ST_RUN : ST_FLUSH;
            default:  state_next = ST_RUN;
        endcase
    end

    always_comb begin
        stall    = 6'b000000;
        flush    = 1'b0;
        new_pc   = ZERO_WORD;
        redirect = 1'b0;
        if (!rst) begin
            case (state)
                ST_RUN: begin
                    if (exc_valid) begin
                        flush  = 1'b1;
                        new_pc = exc_target;
                    end else begin
                        stall = stall_enc;
                        if (fire_redirect) begin
                            redirect = 1'b1;
                            new_pc   = redirect_target;
                        end
                    end
                end
                ST_FLUSH: begin
                    flush  = 1'b1;
                    new_pc = flush_pc;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt <= 2'd0;
            flush_pc  <= ZERO_WORD;
        end else if (exc_entry) begin
            flush_cnt <= FLUSH_LOAD;
            flush_pc  <= exc_target;
        end else if (state == ST_FLUSH && flush_cnt != 2'd0) begin
            flush_cnt <= flush_cnt - 2'd1;
        end
    end

    // One-entry hold for a redirect that arrived while the memory stage was stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_pc    <= ZERO_WORD;
        end else if (exc_entry) begin
            pend_valid <= 1'b0;
        end else if (run_clean) begin
            if (stallreq_mem && mispredict_i) begin
                pend_valid <= 1'b1;
                pend_pc    <= redirect_pc_i;
            end else if (!stallreq_mem) begin
                pend_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt        <= '0;
            stall_timeout <= 1'b0;
        end else if (stall != 6'b000000) begin
            if (to_cnt != TO_LIMIT) to_cnt <= to_cnt + 1'b1;
            if (to_cnt >= TO_LAST)  stall_timeout <= 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           stall_cycles <= ZERO_WORD;
        else if (stall[0]) stall_cycles <= stall_cycles + 32'd1;
    end
`else
    assign stall_cycles = ZERO_WORD;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: driver pushes model expectations, a negedge monitor
// pops and compares every cycle.
module tb_pipe_ctrl;

    localparam int FLUSH_CYCLES  = 2;
    localparam int STALL_TIMEOUT = 1024;
    localparam int TO_W          = 11;
    localparam int W             = 73;

    logic        clk, rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic [31:0] excepttype_i, cp0_epc_i, redirect_pc_i;
    logic        mispredict_i;
    logic [5:0]  stall;
    logic        flush, redirect, stall_timeout;
    logic [31:0] new_pc, stall_cycles;

    pipe_ctrl #(
        .FLUSH_CYCLES(FLUSH_CYCLES), .STALL_TIMEOUT(STALL_TIMEOUT), .TO_W(TO_W)
    ) dut (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .excepttype_i(excepttype_i), .cp0_epc_i(cp0_epc_i),
        .mispredict_i(mispredict_i), .redirect_pc_i(redirect_pc_i),
        .stall(stall), .flush(flush), .new_pc(new_pc), .redirect(redirect),
        .stall_timeout(stall_timeout), .stall_cycles(stall_cycles)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    // reference model state
    int          flush_left;
    logic [31:0] flush_pc;
    bit          pend;
    logic [31:0] pend_pc;
    int          run_len;
    bit          to_flag;
    logic [31:0] perf;

    task automatic model_reset();
        flush_left = 0; flush_pc = 0; pend = 0; pend_pc = 0;
        run_len = 0; to_flag = 0; perf = 0;
    endtask

    task automatic check_field(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive_idle();
        {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'b0000;
        excepttype_i = 0; cp0_epc_i = 0; mispredict_i = 0; redirect_pc_i = 0;
    endtask

    // req = {mem, ex, id, if}
    task automatic step(input logic [3:0] req, input logic [31:0] exc, input logic [31:0] epc,
                        input logic mp, input logic [31:0] rpc);
        logic [5:0]  e_stall;
        logic        e_flush, e_red;
        logic [31:0] e_pc;
        int          depth;
        @(posedge clk); #1;
        {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req;
        excepttype_i = exc; cp0_epc_i = epc; mispredict_i = mp; redirect_pc_i = rpc;
        e_stall = 0; e_flush = 0; e_red = 0; e_pc = 0;
        if (flush_left > 0) begin
            e_flush = 1; e_pc = flush_pc; flush_left--;
        end else if (exc != 0) begin
            e_flush = 1;
            flush_pc = (exc == 32'h0000000e) ? epc : 32'h00000020;
            e_pc = flush_pc;
            flush_left = FLUSH_CYCLES - 1;
            pend = 0;
        end else begin
            // deepest requesting stage freezes itself and everything upstream
            depth = req[3] ? 5 : req[2] ? 4 : req[1] ? 3 : req[0] ? 2 : 0;
            e_stall = 6'((1 << depth) - 1);
            if (req[3]) begin
                if (mp) begin pend = 1; pend_pc = rpc; end
            end else if (mp) begin
                e_red = 1; e_pc = rpc; pend = 0;
            end else if (pend) begin
                e_red = 1; e_pc = pend_pc; pend = 0;
            end
        end
        exp_q.push_back({perf, to_flag, e_red, e_pc, e_flush, e_stall});
        if (e_stall != 0) begin
            run_len++;
            if (run_len >= STALL_TIMEOUT) to_flag = 1;
        end else begin
            run_len = 0;
        end
`ifdef PIPE_PERF_CNT_EN
        if (e_stall[0]) perf = perf + 32'd1;
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, 0, 0, 0, 0);
    endtask

    // hold rst for two cycles expecting all-zero outputs, release after the negedge check
    task automatic reset_cycles();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            drive_idle();
            exp_q.push_back('0);
        end
        #6 rst = 1'b0;
    endtask

    // monitor
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_field("stall",         {26'b0, stall},         {26'b0, e[5:0]});
                check_field("flush",         {31'b0, flush},         {31'b0, e[6]});
                check_field("new_pc",        new_pc,                 e[38:7]);
                check_field("redirect",      {31'b0, redirect},      {31'b0, e[39]});
                check_field("stall_timeout", {31'b0, stall_timeout}, {31'b0, e[40]});
                check_field("stall_cycles",  stall_cycles,           e[72:41]);
            end
        end
    end

    initial begin
        logic [3:0]  req;
        logic [31:0] exc;
        rst = 1'b1;
        drive_idle();
        model_reset();
        reset_cycles();

        idle(10);

        // id+ex together, then ex drops, then both drop
        repeat (3) step(4'b0110, 0, 0, 0, 0);
        step(4'b0010, 0, 0, 0, 0);
        step(4'b0000, 0, 0, 0, 0);

        // exception beats mem stall; second exception during flush is ignored
        step(4'b1000, 32'h00000008, 0, 0, 0);
        step(4'b1000, 32'h0000000e, 32'h12345678, 0, 0);
        step(4'b1000, 0, 0, 0, 0);
        idle(2);

        // eret returns to EPC
        step(4'b0000, 32'h0000000e, 32'hBFC00100, 0, 0);
        idle(3);

        // mispredict held off by mem stall, fires on first unstalled cycle
        step(4'b1000, 0, 0, 1, 32'h00400010);
        step(4'b1000, 0, 0, 0, 0);
        idle(2);
        // exception wins over a same-cycle mispredict
        step(4'b0000, 32'h00000004, 0, 1, 32'h00400040);
        idle(3);
        // pending redirect dropped by a later exception
        step(4'b1000, 0, 0, 1, 32'h00400080);
        step(4'b1000, 32'h0000000c, 0, 0, 0);
        idle(3);

        // asynchronous reset mid-flush
        step(4'b1000, 32'h00000008, 0, 0, 0);
        #6 rst = 1'b1;
        #1;
        check_field("async_rst_stall",    {26'b0, stall},    32'h0);
        check_field("async_rst_flush",    {31'b0, flush},    32'h0);
        check_field("async_rst_redirect", {31'b0, redirect}, 32'h0);
        check_field("async_rst_new_pc",   new_pc,            32'h0);
        model_reset();
        reset_cycles();
        idle(2);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < 4; b++) req[b] = ($urandom_range(0, 3) == 0);
            exc = 0;
            case ($urandom_range(0, 11))
                0: exc = 32'h0000000e;
                1: exc = $urandom_range(1, 31) << 2;
                default: exc = 0;
            endcase
            step(req, exc, $urandom, ($urandom_range(0, 4) == 0), $urandom);
        end
        idle(2);

        // hung stall: watchdog trips after STALL_TIMEOUT cycles and stays set
        repeat (STALL_TIMEOUT + 4) step(4'b0100, 0, 0, 0, 0);
        idle(5);

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries never compared, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
